mod_counter_chain: RTL and testbench

- Parametrised successor to the single 4-bit decade counter: a cascade of NUM_DIGITS modulo-MODULUS digits, BCD-style (least significant digit first).
- Adds count enable, up/down direction, synchronous parallel load, a terminal-count output for chaining further instances, and a sticky wrap flag.
- Used as an event/time counter feeding display and timing logic in lab designs.

---
 rtl/mod_counter_pkg.sv | 20 ++
 rtl/mod_digit.sv | 47 ++++
 rtl/mod_counter_chain.sv | 72 +++++++
 tb/tb_mod_counter_chain.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/mod_counter_pkg.sv
// Shared types and helpers for the modulo counter chain.
// Build with MOD_COUNTER_SAT_EN defined to make the chain saturate instead of wrap.
package mod_counter_pkg;

   typedef enum logic {
      DIR_DOWN = 1'b0,
      DIR_UP   = 1'b1
   } dir_e;

   // Widest digit supported (MODULUS up to 16).
   localparam int TERM_W = 4;

   function automatic logic [TERM_W-1:0] term_val(input dir_e dir, input int modulus);
      logic [TERM_W-1:0] v;
      v = '0;
      if (dir == DIR_UP) v = TERM_W'(modulus - 1);
      return v;
   endfunction

endpackage

// File: rtl/mod_digit.sv
// One modulo-MODULUS digit: parallel load with clamping, up/down step, terminal flag.
// Saturation (MOD_COUNTER_SAT_EN) is handled by the top gating step.
module mod_digit
   import mod_counter_pkg::*;
#(
   parameter int MODULUS = 10,
   parameter int DIGIT_W = $clog2(MODULUS)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               step,
   input  logic               up_dn,
   input  logic               load,
   input  logic [DIGIT_W-1:0] load_d,
   output logic [DIGIT_W-1:0] q,
   output logic               at_term
);

   localparam logic [DIGIT_W-1:0] MAX_V = DIGIT_W'(MODULUS - 1);
   localparam logic [DIGIT_W:0]   MOD_V = (DIGIT_W + 1)'(MODULUS);

   logic [DIGIT_W-1:0] q_q, q_d;
   logic [DIGIT_W-1:0] load_clamped;

   always_comb begin
      load_clamped = load_d;
      // Out-of-range load digits land on the top legal value.
      if ({1'b0, load_d} >= MOD_V) load_clamped = MAX_V;

      q_d = q_q;
      if (load) begin
         q_d = load_clamped;
      end else if (step) begin
         if (up_dn) q_d = (q_q == MAX_V) ? '0 : q_q + 1'b1;
         else       q_d = (q_q == '0) ? MAX_V : q_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) q_q <= '0;
      else        q_q <= q_d;
   end

   assign q       = q_q;
   assign at_term = (TERM_W'(q_q) == term_val(dir_e'(up_dn), MODULUS));

endmodule

// File: rtl/mod_counter_chain.sv
// Cascade of NUM_DIGITS modulo-MODULUS digits (digit 0 least significant) with
// terminal count and sticky wrap flag; MOD_COUNTER_SAT_EN selects saturation over wrap.
module mod_counter_chain
   import mod_counter_pkg::*;
#(
   parameter int NUM_DIGITS = 4,
   parameter int MODULUS    = 10,
   parameter int DIGIT_W    = $clog2(MODULUS)
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          en,
   input  logic                          up_dn,
   input  logic                          load,
   input  logic [NUM_DIGITS*DIGIT_W-1:0] load_val,
   output logic [NUM_DIGITS*DIGIT_W-1:0] count,
   output logic                          tc,
   output logic                          wrapped
);

   logic [NUM_DIGITS-1:0] at_term;
   logic [NUM_DIGITS-1:0] step;
   logic [NUM_DIGITS:0]   carry;
   logic                  sat_hold;
   logic                  wrapped_q, wrapped_d;

   // carry[i] is high when every digit below i sits at its terminal value.
   assign carry[0] = 1'b1;

   for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
      assign carry[g+1] = carry[g] & at_term[g];
      assign step[g]    = en & ~load & carry[g] & ~sat_hold;

      mod_digit #(
         .MODULUS (MODULUS),
         .DIGIT_W (DIGIT_W)
      ) u_digit (
         .clk     (clk),
         .reset   (reset),
         .step    (step[g]),
         .up_dn   (up_dn),
         .load    (load),
         .load_d  (load_val[g*DIGIT_W +: DIGIT_W]),
         .q       (count[g*DIGIT_W +: DIGIT_W]),
         .at_term (at_term[g])
      );
   end

   assign tc = en & ~load & carry[NUM_DIGITS];

`ifdef MOD_COUNTER_SAT_EN
   // At terminal count every digit already holds the saturation value; freezing
   // the steps keeps it there until the direction flips.
   assign sat_hold = tc;
`else
   assign sat_hold = 1'b0;
`endif

   always_comb begin
      wrapped_d = wrapped_q;
      if (load)    wrapped_d = 1'b0;
      else if (tc) wrapped_d = 1'b1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) wrapped_q <= 1'b0;
      else        wrapped_q <= wrapped_d;
   end

   assign wrapped = wrapped_q;

endmodule

// File: tb/tb_mod_counter_chain.sv
// Directed + random bench for mod_counter_chain (2 digits, modulus 10) and a
// two-instance modulus-6 chain; a value-domain model feeds an expected queue.
module tb_mod_counter_chain;

   localparam int ND  = 2;
   localparam int MOD = 10;
   localparam int TOT = MOD * MOD;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       en = 1'b0;
   logic       up_dn = 1'b1;
   logic       load = 1'b0;
   logic [7:0] load_val = '0;
   logic [7:0] count;
   logic       tc;
   logic       wrapped;

   // modulus-6 chain: lower tc drives upper en
   logic       c_reset = 1'b0;
   logic       c_en = 1'b0;
   logic [5:0] c_lo_count, c_hi_count;
   logic       c_lo_tc, c_hi_tc, c_lo_wr, c_hi_wr;

   int n_pass = 0;
   int n_fail = 0;
   int n_total = 0;

   int   m_val = 0;
   logic m_wr  = 1'b0;
   logic [8:0] exp_q[$];

   always #5 clk = ~clk;

   mod_counter_chain #(.NUM_DIGITS(ND), .MODULUS(MOD)) dut (
      .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load),
      .load_val(load_val), .count(count), .tc(tc), .wrapped(wrapped)
   );

   mod_counter_chain #(.NUM_DIGITS(2), .MODULUS(6)) u_lo (
      .clk(clk), .reset(c_reset), .en(c_en), .up_dn(1'b1), .load(1'b0),
      .load_val(6'd0), .count(c_lo_count), .tc(c_lo_tc), .wrapped(c_lo_wr)
   );

   mod_counter_chain #(.NUM_DIGITS(2), .MODULUS(6)) u_hi (
      .clk(clk), .reset(c_reset), .en(c_lo_tc), .up_dn(1'b1), .load(1'b0),
      .load_val(6'd0), .count(c_hi_count), .tc(c_hi_tc), .wrapped(c_hi_wr)
   );

   function automatic logic [7:0] to_cnt(input int v);
      return {4'(v / 10), 4'(v % 10)};
   endfunction

   function automatic int clamp_val(input logic [7:0] lv);
      int hi, lo;
      hi = int'(lv[7:4]);
      lo = int'(lv[3:0]);
      if (hi > MOD - 1) hi = MOD - 1;
      if (lo > MOD - 1) lo = MOD - 1;
      return hi * MOD + lo;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Drive one cycle, check tc before the edge, push the model's next state,
   // then pop and compare after the edge.
   task automatic drive_cycle(input logic e, input logic u, input logic l, input logic [7:0] lv);
      logic       exp_tc;
      logic [8:0] got;
      en = e; up_dn = u; load = l; load_val = lv;
      #1;
      exp_tc = e & ~l & ((u && m_val == TOT - 1) || (!u && m_val == 0));
      check("tc", 32'(tc), 32'(exp_tc));
      if (l) begin
         m_val = clamp_val(lv);
         m_wr  = 1'b0;
      end else if (e) begin
         if (exp_tc) begin
            m_wr = 1'b1;
`ifndef MOD_COUNTER_SAT_EN
            m_val = u ? 0 : TOT - 1;
`endif
         end else begin
            m_val = u ? m_val + 1 : m_val - 1;
         end
      end
      exp_q.push_back({m_wr, to_cnt(m_val)});
      @(posedge clk);
      #1;
      got = exp_q.pop_front();
      check("count", 32'(count), 32'(got[7:0]));
      check("wrapped", 32'(wrapped), 32'(got[8]));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      // reset held for two cycles
      repeat (2) @(posedge clk);
      #1;
      check("rst_count", 32'(count), 32'h0);
      check("rst_wrapped", 32'(wrapped), 32'h0);
      check("rst_tc", 32'(tc), 32'h0);
      reset = 1'b1;

      // count up 15 steps
      for (int i = 0; i < 15; i++) drive_cycle(1'b1, 1'b1, 1'b0, 8'h00);
      check("count_15", 32'(count), 32'h15);

      // load 0x98 with en high: load wins, then wrap up
      drive_cycle(1'b1, 1'b1, 1'b1, 8'h98);
      check("load_98", 32'(count), 32'h98);
      for (int i = 0; i < 3; i++) drive_cycle(1'b1, 1'b1, 1'b0, 8'h00);

      // load 0x01, count down through wrap, then reload clears wrapped
      drive_cycle(1'b0, 1'b0, 1'b1, 8'h01);
      for (int i = 0; i < 3; i++) drive_cycle(1'b1, 1'b0, 1'b0, 8'h00);
      drive_cycle(1'b0, 1'b0, 1'b1, 8'h50);
      check("reload_clear", 32'(wrapped), 32'h0);

      // clamping of out-of-range digits
      drive_cycle(1'b1, 1'b1, 1'b1, 8'hFC);
      check("clamp_FC", 32'(count), 32'h99);
      drive_cycle(1'b0, 1'b1, 1'b1, 8'h3F);
      check("clamp_3F", 32'(count), 32'h39);

      // en low holds, direction change mid-count
      for (int i = 0; i < 3; i++) drive_cycle(1'b0, 1'b1, 1'b0, 8'h00);
      for (int i = 0; i < 4; i++) drive_cycle(1'b1, 1'b1, 1'b0, 8'h00);
      for (int i = 0; i < 6; i++) drive_cycle(1'b1, 1'b0, 1'b0, 8'h00);

      // saturation / wrap at the top, then direction flip
      drive_cycle(1'b0, 1'b1, 1'b1, 8'h99);
      for (int i = 0; i < 3; i++) drive_cycle(1'b1, 1'b1, 1'b0, 8'h00);
      for (int i = 0; i < 3; i++) drive_cycle(1'b1, 1'b0, 1'b0, 8'h00);

      // asynchronous reset mid-cycle at 0x47
      drive_cycle(1'b0, 1'b1, 1'b1, 8'h47);
      en = 1'b1;
      #2;
      reset = 1'b0;
      #1;
      check("async_count", 32'(count), 32'h0);
      check("async_wrapped", 32'(wrapped), 32'h0);
      m_val = 0;
      m_wr  = 1'b0;
      @(posedge clk);
      #1;
      check("in_reset_hold", 32'(count), 32'h0);
      reset = 1'b1;
      for (int i = 0; i < 3; i++) drive_cycle(1'b1, 1'b1, 1'b0, 8'h00);

      // random traffic against the model
      for (int i = 0; i < 60; i++) begin
         drive_cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 9) == 0), 8'($urandom_range(0, 255)));
      end

      // two chained modulus-6 instances, 36 up steps
      c_reset = 1'b1;
      c_en = 1'b1;
      repeat (36) @(posedge clk);
      #1;
      c_en = 1'b0;
      check("chain_hi", 32'(c_hi_count), 32'h01);
`ifdef MOD_COUNTER_SAT_EN
      check("chain_lo", 32'(c_lo_count), 32'({3'd5, 3'd5}));
`else
      check("chain_lo", 32'(c_lo_count), 32'h0);
`endif
      check("chain_lo_wr", 32'(c_lo_wr), 32'h1);
      check("chain_hi_wr", 32'(c_hi_wr), 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
